if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage RV32I core. It owns the architectural fetch PC and issues single-outstanding word reads to the instruction memory port. It presents {if_pc, if_inst} to the IF/ID pipeline register, and it honours the global stall vector and flush/redirect from the branch unit. It buffers one returned instruction when IF is stalled, and drops responses made stale by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
STAGE_NUM, 6, width of global stall vector
IF_IDX, 1, bit of stall vector belonging to IF
NOP_INST, 32'h0000_0013, instruction driven when no valid fetch (addi x0,x0,0)

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
stall  input  STAGE_NUM  global stall vector; 1 = stop
flush  input  1  redirect request from branch/exception unit
redirect_pc  input  32  new fetch PC, valid when flush=1
im_req  output  1  instruction memory read request
im_addr  output  32  word address of request, bits[1:0]=0
im_gnt  input  1  request accepted this cycle
im_rvalid  input  1  read data valid
im_rdata  input  32  read data
if_pc  output  32  PC of presented instruction (0 when invalid)
if_inst  output  32  presented instruction (NOP_INST when invalid)
stallreq_if  output  1  1 = no valid instruction presented this cycle

Behaviour:
- Registers: state, pc_q (PC of the pending/held fetch), req_addr, inst_buf, kill. Clock is clk only; rstn is asynchronous and active-low.
- Reset (asynchronous, active-low, immediate):
  - state=REQ, pc_q=req_addr=RESET_PC, kill=0, inst_buf=NOP_INST.
  - While rstn=0: im_req=0, if_pc=0, if_inst=NOP_INST, stallreq_if=1.
- State REQ:
  - im_req=1, im_addr=req_addr.
  - req_addr must stay stable until im_gnt=1.
  - On im_gnt go to WAIT.
- State WAIT:
  - im_req=0. Wait for im_rvalid, with unbounded latency.
- State HOLD:
  - im_req=0. inst_buf holds a valid instruction for pc_q.
- Valid instruction is presented when either:
  - (WAIT & im_rvalid & ~kill & ~flush): combinational bypass, if_inst=im_rdata; or
  - (HOLD & ~flush): if_inst=inst_buf.
  - In both cases if_pc=pc_q and stallreq_if=0. Otherwise if_pc=0, if_inst=NOP_INST, stallreq_if=1.
- Consume = valid & stall[IF_IDX]=0. On consume:
  - pc_q<=pc_q+4 and req_addr<=pc_q+4 (32-bit wrap, carry ignored).
  - state<=REQ.
- Valid but stall[IF_IDX]=1:
  - From WAIT: inst_buf<=im_rdata, state<=HOLD.
  - In HOLD: hold with no change and no new request.
- Latency: with im_gnt in the REQ cycle and im_rvalid one cycle later, the instruction appears 1 cycle after the request. Steady throughput is 1 instruction per 2 cycles.
- Flush (priority over consume/buffer). In every state pc_q<=redirect_pc with bits[1:0] cleared. Per-state action:
  - REQ with ~im_gnt: keep im_addr=req_addr (stale, held stable) and set kill=1.
  - REQ with im_gnt: go to WAIT with kill=1.
  - WAIT with im_rvalid: drop the data, go to REQ, req_addr<=redirect_pc.
  - WAIT without im_rvalid: set kill=1.
  - HOLD: discard inst_buf, go to REQ, req_addr<=redirect_pc.
- kill handling:
  - In WAIT with kill=1, im_rvalid drops the data, clears kill, goes to REQ, and sets req_addr<=pc_q (the redirected PC).
  - In REQ with kill=1 and im_gnt, go to WAIT keeping kill=1.
  - Outside those cases kill holds.
- Repeated flush while kill=1: pc_q takes the latest redirect_pc; only one drop occurs per outstanding request.
- im_rvalid in REQ or HOLD: ignored.
- stall[IF_IDX]=1 does not block issuing a request in REQ; it only blocks consumption.
- Async reset mid-transaction abandons the transaction. The memory shares rstn, so no orphan response is expected.

Test Plan:
- Reset → rstn=0 gives im_req=0, if_inst=0x13, if_pc=0, stallreq_if=1. The first cycle after release has im_req=1, im_addr=0x0.
- Straight line, im_gnt same cycle, im_rvalid next cycle with rdata 0x00500093 → if_pc=0x0, if_inst=0x00500093, stallreq_if=0 that cycle. Next request has im_addr=0x4, then the instruction for 0x8 is consumed 2 cycles later.
- rvalid for PC 0x4 (rdata 0x00A00113) while stall[IF_IDX]=1 for 3 cycles → if_pc=0x4/if_inst=0x00A00113 held all 3 cycles and im_req=0. When the stall releases it is consumed, then im_addr=0x8.
- Request for 0x8 granted, flush with redirect_pc=0x100 in WAIT, rvalid 2 cycles later → data dropped, if_inst=0x13, stallreq_if=1. The next request has im_addr=0x100; its response is presented with if_pc=0x100.
- im_gnt low 2 cycles with im_addr=0x10, flush redirect_pc=0x203 during that window → im_addr stays 0x10 until grant. The response is dropped, then im_addr=0x200.
- Flush asserted in the same cycle as im_rvalid with stall=0 → no consumption, if_inst=0x13, next im_addr=redirect_pc. Async rstn pulse in WAIT → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding word reads,
// presents {if_pc, if_inst} to IF/ID and handles stall, flush/redirect and stale responses.
//
// state  | meaning
// S_REQ  | request for req_addr on the memory port, waiting for grant
// S_WAIT | request granted, waiting for read data (dropped if kill is set)
// S_HOLD | inst_buf holds the instruction for pc_q while IF is stalled
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          STAGE_NUM = 6,
  parameter int          IF_IDX    = 1,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [STAGE_NUM-1:0] stall,
  input  logic                 flush,
  input  logic [31:0]          redirect_pc,
  output logic                 im_req,
  output logic [31:0]          im_addr,
  input  logic                 im_gnt,
  input  logic                 im_rvalid,
  input  logic [31:0]          im_rdata,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_inst,
  output logic                 stallreq_if
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] inst_buf, inst_buf_n;
  logic        kill, kill_n;
  logic        valid;
  logic        stall_if;
  logic [31:0] redirect_al;
  logic [31:0] pc_inc;
  logic        unused_ok;

  assign stall_if    = stall[IF_IDX];
  assign redirect_al = {redirect_pc[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;
  assign unused_ok   = ^{stall, redirect_pc[1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_REQ;
      pc_q     <= RESET_PC;
      req_addr <= RESET_PC;
      inst_buf <= NOP_INST;
      kill     <= 1'b0;
    end else begin
      state    <= state_n;
      pc_q     <= pc_n;
      req_addr <= req_addr_n;
      inst_buf <= inst_buf_n;
      kill     <= kill_n;
    end
  end

  // Outputs are forced to their idle values while reset is held, independent of the clock.
  always_comb begin
    valid = 1'b0;
    if (rstn && !flush) begin
      case (state)
        S_WAIT:  valid = im_rvalid && !kill;
        S_HOLD:  valid = 1'b1;
        default: valid = 1'b0;
      endcase
    end
    im_req      = rstn && (state == S_REQ);
    im_addr     = req_addr;
    if_pc       = valid ? pc_q : 32'd0;
    if_inst     = !valid ? NOP_INST : ((state == S_HOLD) ? inst_buf : im_rdata);
    stallreq_if = !valid;
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    req_addr_n = req_addr;
    inst_buf_n = inst_buf;
    kill_n     = kill;
    if (flush) begin
      pc_n = redirect_al;
      case (state)
        S_REQ: begin
          // An ungranted request keeps its stale address; its response is dropped later.
          kill_n = 1'b1;
          if (im_gnt) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (im_rvalid) begin
            state_n    = S_REQ;
            req_addr_n = redirect_al;
            kill_n     = 1'b0;
          end else begin
            kill_n = 1'b1;
          end
        end
        S_HOLD: begin
          state_n    = S_REQ;
          req_addr_n = redirect_al;
          inst_buf_n = NOP_INST;
        end
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (im_gnt) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (im_rvalid) begin
            if (kill) begin
              kill_n     = 1'b0;
              state_n    = S_REQ;
              req_addr_n = pc_q;
            end else if (!stall_if) begin
              pc_n       = pc_inc;
              req_addr_n = pc_inc;
              state_n    = S_REQ;
            end else begin
              inst_buf_n = im_rdata;
              state_n    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_if) begin
            pc_n       = pc_inc;
            req_addr_n = pc_inc;
            state_n    = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with random grant/latency, scoreboard of the
// expected consumed PC stream, directed corner cases followed by a randomized run.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          STAGE_NUM = 6;
  localparam int          IF_IDX    = 1;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [STAGE_NUM-1:0] stall;
  logic                 flush;
  logic [31:0]          redirect_pc;
  logic                 im_req;
  logic [31:0]          im_addr;
  logic                 im_gnt;
  logic                 im_rvalid;
  logic [31:0]          im_rdata;
  logic [31:0]          if_pc;
  logic [31:0]          if_inst;
  logic                 stallreq_if;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .STAGE_NUM(STAGE_NUM),
    .IF_IDX   (IF_IDX),
    .NOP_INST (NOP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_gnt     (im_gnt),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .stallreq_if(stallreq_if)
  );

  int tests = 0;
  int fails = 0;

  // stimulus knobs (percentages / latency range)
  int p_gnt = 100, min_lat = 0, max_lat = 0, p_stall = 0, p_flush = 0;
  bit spurious = 1'b0;
  bit force_flush = 1'b0;
  logic [31:0] force_target = '0;

  // memory model and scoreboard
  bit          outstanding = 1'b0;
  logic [31:0] out_addr = '0;
  int          lat = 0;
  logic [31:0] exp_q[$];
  int          consumed = 0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  // Odd multiplier is a bijection, so every address has distinct contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
    return $urandom & 32'h0000_0FFF;
  endfunction

  // driver: inputs change 1 time unit after each rising edge
  initial begin
    stall = '0; flush = 1'b0; redirect_pc = '0;
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        stall = '0; flush = 1'b0; im_gnt = 1'b0; im_rvalid = 1'b0;
      end else begin
        stall = STAGE_NUM'($urandom);
        stall[IF_IDX] = ($urandom_range(0, 99) < p_stall);
        flush = 1'b0;
        if (force_flush || ($urandom_range(0, 99) < p_flush)) begin
          flush = 1'b1;
          redirect_pc = force_flush ? force_target : rand_target();
          force_flush = 1'b0;
          exp_q.delete();
          exp_q.push_back({redirect_pc[31:2], 2'b00});
        end
        im_gnt = im_req && ($urandom_range(0, 99) < p_gnt);
        if (outstanding && lat == 0) begin
          im_rvalid = 1'b1; im_rdata = mem_word(out_addr);
        end else if (spurious && !outstanding && im_req && $urandom_range(0, 9) == 0) begin
          im_rvalid = 1'b1; im_rdata = $urandom;
        end else begin
          im_rvalid = 1'b0; im_rdata = $urandom;
        end
      end
    end
  end

  // monitor: samples on the falling edge
  always @(negedge clk) begin
    if (rstn) begin
      if (im_req) chk("addr_align", 32'(im_addr[1:0]), 32'd0);
      if (im_req && prev_pend) chk("addr_stable", im_addr, prev_addr);
      if (flush) chk("flush_blocks_valid", 32'(stallreq_if), 32'd1);
      if (stallreq_if) begin
        chk("idle_pc", if_pc, 32'd0);
        chk("idle_inst", if_inst, NOP);
      end else begin
        chk("no_req_while_valid", 32'(im_req), 32'd0);
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          chk("if_pc", if_pc, exp_q[0]);
          chk("if_inst", if_inst, mem_word(exp_q[0]));
          if (!stall[IF_IDX]) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            exp_q.push_back(e + 32'd4);
            consumed++;
          end
        end
      end
      if (outstanding && im_rvalid) outstanding = 1'b0;
      else if (outstanding) lat--;
      if (im_req && im_gnt) begin
        if (outstanding) chk("single_outstanding", 32'd1, 32'd0);
        outstanding = 1'b1;
        out_addr = im_addr;
        lat = $urandom_range(min_lat, max_lat);
      end
      prev_pend = im_req && !im_gnt;
      prev_addr = im_addr;
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, h;
    int c0;
    bit hit;
    exp_q.push_back(RESET_PC);
    #2;
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_stallreq", 32'(stallreq_if), 32'd1);
    #10 rstn = 1'b1;

    // straight-line flow: 1-cycle latency, one instruction per two cycles
    tick(); chk("first_req", 32'(im_req), 32'd1); chk("first_addr", im_addr, RESET_PC);
    tick(); chk("first_valid", 32'(stallreq_if), 32'd0); chk("first_pc", if_pc, RESET_PC);
    tick(); chk("second_addr", im_addr, RESET_PC + 4);
    tick(); chk("second_pc", if_pc, RESET_PC + 4);
    tick(); chk("third_addr", im_addr, RESET_PC + 8);
    tick(); chk("third_pc", if_pc, RESET_PC + 8);

    // IF stalled while data returns: held for three cycles, then consumed
    p_stall = 100;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin tick(); hit = !stallreq_if; end
    chk("stall_valid_seen", 32'(hit), 32'd1);
    h = if_pc;
    for (int i = 0; i < 3; i++) begin
      chk("held_pc", if_pc, h);
      chk("held_inst", if_inst, mem_word(h));
      chk("held_no_req", 32'(im_req), 32'd0);
      if (i < 2) tick();
    end
    p_stall = 0;
    tick(); chk("held_release_pc", if_pc, h);
    tick(); chk("after_hold_addr", im_addr, h + 4);

    // flush in WAIT, response arrives two cycles later and is dropped
    min_lat = 2; max_lat = 2;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin tick(); hit = outstanding && lat == 2; end
    force_target = 32'h100; force_flush = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin tick(); hit = im_req && im_gnt; end
    chk("wait_flush_req_seen", 32'(hit), 32'd1);
    chk("wait_flush_addr", im_addr, 32'h100);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin tick(); hit = !stallreq_if; end
    chk("redirect_pc_seen", if_pc, 32'h100);

    // flush while grant is held off: stale address held, then redirected fetch
    min_lat = 0; max_lat = 0; p_gnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin tick(); hit = im_req; end
    a = im_addr;
    force_target = 32'h203; force_flush = 1'b1;
    tick(); chk("nognt_addr_hold", im_addr, a);
    tick(); chk("nognt_addr_hold", im_addr, a);
    p_gnt = 100;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin tick(); hit = im_req && im_gnt; end
    chk("stale_req_addr", im_addr, a);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin tick(); hit = im_req && im_gnt; end
    chk("redirect_203_addr", im_addr, 32'h200);

    // flush in the same cycle as read data
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin tick(); hit = outstanding; end
    force_target = 32'h40; force_flush = 1'b1;
    tick();
    chk("flush_rvalid_stallreq", 32'(stallreq_if), 32'd1);
    chk("flush_rvalid_inst", if_inst, NOP);
    tick(); chk("flush_rvalid_req", 32'(im_req), 32'd1); chk("flush_rvalid_addr", im_addr, 32'h40);

    // asynchronous reset while a request is outstanding
    min_lat = 3; max_lat = 3;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin tick(); hit = outstanding; end
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    chk("async_rst_req", 32'(im_req), 32'd0);
    chk("async_rst_pc", if_pc, 32'd0);
    chk("async_rst_inst", if_inst, NOP);
    chk("async_rst_stallreq", 32'(stallreq_if), 32'd1);
    outstanding = 1'b0; lat = 0;
    exp_q.delete(); exp_q.push_back(RESET_PC);
    #8 rstn = 1'b1;
    tick(); chk("post_rst_req", 32'(im_req), 32'd1); chk("post_rst_addr", im_addr, RESET_PC);

    // randomized traffic
    p_gnt = 60; min_lat = 0; max_lat = 3; p_stall = 30; p_flush = 5; spurious = 1'b1;
    c0 = consumed;
    repeat (3000) tick();
    chk("random_progress", 32'(consumed - c0 > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
